// File: rtl/vreg_group_addr_gen_if.sv
// Handshake bundle between the register-group address generator and its scheduler/VRF port.
// The master side is the generator: it takes the load configuration and addr_ready, and drives the address stream.
interface vreg_group_addr_gen_if #(
   parameter int AW      = 9,
   parameter int NUM_SEG = 8,
   parameter int SW      = 4
);
   logic [NUM_SEG*AW-1:0] start_addr;
   logic [SW-1:0]         seg_cnt;
   logic [AW-1:0]         slide_offset;
   logic                  up_down;
   logic [1:0]            sew;
   logic                  load;
   logic                  addr_ready;
   logic [AW-1:0]         addr;
   logic                  addr_valid;
   logic                  last;
   logic                  busy;
   logic                  done;

   modport master (
      input  start_addr, seg_cnt, slide_offset, up_down, sew, load, addr_ready,
      output addr, addr_valid, last, busy, done
   );

   modport slave (
      output start_addr, seg_cnt, slide_offset, up_down, sew, load, addr_ready,
      input  addr, addr_valid, last, busy, done
   );
endinterface

// File: rtl/vreg_group_addr_gen.sv
// Per-lane VRF address walker over a 1..NUM_SEG register group. The first address is valid one cycle after load; addr, last and the counters hold while addr_ready is low.
// Descending traversal exists only when VREG_ADDR_GEN_DOWN_EN is defined; otherwise up_down is ignored and the walk is always ascending.
module vreg_group_addr_gen #(
   parameter int MEM_DEPTH         = 512,
   parameter int VREG_LOC_PER_LANE = 8,
   parameter int NUM_SEG           = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   vreg_group_addr_gen_if.master bus
);
   localparam int AW  = $clog2(MEM_DEPTH);
   localparam int SW  = $clog2(NUM_SEG) + 1;
   localparam int SIW = $clog2(NUM_SEG);
   localparam int CW  = $clog2(VREG_LOC_PER_LANE * 4);

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  base_q [NUM_SEG];
   logic [SW-1:0]  seg_cnt_q;
   logic [AW-1:0]  off_q;
   logic [1:0]     sew_q;
   logic [CW-1:0]  lim_q;
   logic [CW-1:0]  cnt_q;
   logic [SW-1:0]  seg_q;
   logic           done_q;

   logic           load_ok, xfer, up_in;
   logic [SW-1:0]  seg_cnt_eff, seg_last;
   logic           term_w, fin_w, first_w, last_w;
   logic [CW-1:0]  elem;
   logic [AW-1:0]  addr_w;

   function automatic logic [CW-1:0] lim_of(input logic [1:0] s);
      int v;
      v = VREG_LOC_PER_LANE * (4 >> s) - 1;
      return v[CW-1:0];
   endfunction

   assign load_ok  = bus.load && (bus.sew != 2'b11);
   assign xfer     = (state_q == RUN) && bus.addr_ready;
   assign seg_last = seg_cnt_q - SW'(1);

`ifdef VREG_ADDR_GEN_DOWN_EN
   logic up_q;
   assign up_in   = bus.up_down;
   assign term_w  = up_q ? (cnt_q == lim_q) : (cnt_q == '0);
   assign fin_w   = up_q ? (seg_q == seg_last) : (seg_q == '0);
   assign first_w = up_q ? (seg_q == '0) : (seg_q == seg_last);
`else
   logic unused_up_down;
   assign unused_up_down = bus.up_down;
   assign up_in   = 1'b1;
   assign term_w  = (cnt_q == lim_q);
   assign fin_w   = (seg_q == seg_last);
   assign first_w = (seg_q == '0);
`endif
   assign last_w = term_w && fin_w;

   // 0 means a single register; anything beyond NUM_SEG saturates.
   always_comb begin
      seg_cnt_eff = bus.seg_cnt;
      if (bus.seg_cnt == '0)
         seg_cnt_eff = SW'(1);
      else if (bus.seg_cnt > SW'(NUM_SEG))
         seg_cnt_eff = SW'(NUM_SEG);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load_ok) state_d = RUN;
         RUN:     if (load_ok) state_d = RUN;
                  else if (xfer && last_w) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < NUM_SEG; k++) base_q[k] <= '0;
         seg_cnt_q <= '0;
         off_q     <= '0;
         sew_q     <= '0;
         lim_q     <= '0;
         cnt_q     <= '0;
         seg_q     <= '0;
         done_q    <= 1'b0;
`ifdef VREG_ADDR_GEN_DOWN_EN
         up_q      <= 1'b0;
`endif
      end else begin
         // A restart suppresses the done pulse of the run it replaces.
         done_q <= xfer && last_w && !load_ok;
         if (load_ok) begin
            for (int k = 0; k < NUM_SEG; k++) base_q[k] <= bus.start_addr[k*AW +: AW];
            seg_cnt_q <= seg_cnt_eff;
            off_q     <= bus.slide_offset;
            sew_q     <= bus.sew;
            lim_q     <= lim_of(bus.sew);
`ifdef VREG_ADDR_GEN_DOWN_EN
            up_q      <= up_in;
            cnt_q     <= up_in ? '0 : lim_of(bus.sew);
            seg_q     <= up_in ? '0 : seg_cnt_eff - SW'(1);
`else
            cnt_q     <= '0;
            seg_q     <= '0;
`endif
         end else if (xfer && !last_w) begin
`ifdef VREG_ADDR_GEN_DOWN_EN
            if (term_w) begin
               seg_q <= up_q ? seg_q + SW'(1) : seg_q - SW'(1);
               cnt_q <= up_q ? '0 : lim_q;
            end else begin
               cnt_q <= up_q ? cnt_q + CW'(1) : cnt_q - CW'(1);
            end
`else
            if (term_w) begin
               seg_q <= seg_q + SW'(1);
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
`endif
         end
      end
   end

   // Element count is in SEW units; four bytes share one 32-bit VRF word.
   always_comb begin
      case (sew_q)
         2'b00:   elem = cnt_q >> 2;
         2'b01:   elem = cnt_q >> 1;
         default: elem = cnt_q;
      endcase
      addr_w = base_q[seg_q[SIW-1:0]] + AW'(elem);
      if (first_w) begin
`ifdef VREG_ADDR_GEN_DOWN_EN
         addr_w = up_q ? addr_w + off_q : addr_w - off_q;
`else
         addr_w = addr_w + off_q;
`endif
      end
   end

   always_comb begin
      bus.addr_valid = (state_q == RUN);
      bus.busy       = (state_q == RUN);
      bus.last       = (state_q == RUN) && last_w;
      bus.addr       = (state_q == RUN) ? addr_w : '0;
      bus.done       = done_q;
   end
endmodule

// File: tb/tb_vreg_group_addr_gen.sv
// Directed bench for vreg_group_addr_gen: a reference walk fills a scoreboard at each load, transfers are popped and compared.
module tb_vreg_group_addr_gen;
   localparam int AW = 9;
   localparam int NS = 8;
   localparam int SW = 4;

   typedef struct packed {
      logic          last;
      logic [AW-1:0] addr;
   } exp_t;

   logic clk, rst;
   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   vreg_group_addr_gen_if #(.AW(AW), .NUM_SEG(NS), .SW(SW)) bus ();

   vreg_group_addr_gen #(.MEM_DEPTH(512), .VREG_LOC_PER_LANE(8), .NUM_SEG(NS)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [1:0] sew, input logic [3:0] segcnt,
                          input logic [NS*AW-1:0] bases, input logic [AW-1:0] off, input logic up);
      bus.sew          = sew;
      bus.seg_cnt      = segcnt;
      bus.start_addr   = bases;
      bus.slide_offset = off;
      bus.up_down      = up;
   endtask

   // Reference walk: every element of every register, in traversal order.
   task automatic push_run(input int sew, input int segcnt, input logic [NS*AW-1:0] bases,
                           input int off, input bit up);
      int n, lim, s, e, a;
      exp_t x;
      n   = (segcnt == 0) ? 1 : (segcnt > NS) ? NS : segcnt;
      lim = 8 * (4 >> sew) - 1;
      for (int k = 0; k < n; k++) begin
         s = up ? k : n - 1 - k;
         for (int j = 0; j <= lim; j++) begin
            e = up ? j : lim - j;
            a = int'(bases[s*AW +: AW]) + (e >> (2 - sew));
            if (k == 0) a = up ? a + off : a - off;
            x.addr = AW'(a & 511);
            x.last = (k == n - 1) && (j == lim);
            q.push_back(x);
         end
      end
   endtask

   task automatic load_pulse();
      bus.load = 1'b1;
      step();
      bus.load = 1'b0;
   endtask

   // Drains the scoreboard against the DUT; optional stall window, optional early return.
   task automatic run_traffic(input int stall_at, input int stall_len, input int stop_at);
      int beats = 0, cyc = 0, stall_left = 0;
      bit stalled = 0, seen = 0;
      exp_t e;
      while (!seen && cyc < 3000) begin
         if (beats == stop_at) return;
         if (beats == stall_at && !stalled) begin
            stalled    = 1;
            stall_left = stall_len;
         end
         bus.addr_ready = (stall_left == 0);
         @(negedge clk);
         chk("valid_in_run", 32'(bus.addr_valid), 1);
         chk("done_in_run", 32'(bus.done), 0);
         total++;
         assert (q.size() > 0) else begin
            bad++;
            $error("FAIL sb_empty observed=transfer expected=no_more_beats");
            break;
         end
         e = q[0];
         chk("addr", 32'(bus.addr), 32'(e.addr));
         chk("last", 32'(bus.last), 32'(e.last));
         if (bus.addr_ready) begin
            void'(q.pop_front());
            beats++;
            seen = e.last;
         end else begin
            stall_left--;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.addr_ready = 1'b1;
      total++;
      assert (seen) else begin
         bad++;
         $error("FAIL run_end observed=no_last expected=last_transfer");
      end
      @(negedge clk);
      chk("done_pulse", 32'(bus.done), 1);
      chk("valid_after", 32'(bus.addr_valid), 0);
      chk("busy_after", 32'(bus.busy), 0);
      chk("sb_left", 32'(q.size()), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("done_once", 32'(bus.done), 0);
      @(posedge clk);
      #1;
   endtask

   logic [NS*AW-1:0] bases;

   initial begin
      rst            = 1'b1;
      bus.load       = 1'b0;
      bus.addr_ready = 1'b1;
      set_cfg(2'b00, 4'd0, '0, '0, 1'b1);
      step();
      step();
      @(negedge clk);
      chk("rst_valid", 32'(bus.addr_valid), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_last", 32'(bus.last), 0);
      chk("rst_addr", 32'(bus.addr), 0);
      step();
      rst = 1'b0;
      step();

      // word, single register at 16
      bases = '0; bases[0 +: AW] = 9'd16;
      set_cfg(2'b10, 4'd1, bases, 9'd0, 1'b1);
      push_run(2, 1, bases, 0, 1);
      load_pulse();
      run_traffic(-1, 0, -1);

      // byte, two registers at 0 and 64
      bases = '0; bases[AW +: AW] = 9'd64;
      set_cfg(2'b00, 4'd2, bases, 9'd0, 1'b1);
      push_run(0, 2, bases, 0, 1);
      load_pulse();
      run_traffic(-1, 0, -1);

      // descending with slide offset (ascending when the feature is compiled out)
      bases = '0; bases[AW +: AW] = 9'd100;
      set_cfg(2'b10, 4'd2, bases, 9'd2, 1'b0);
`ifdef VREG_ADDR_GEN_DOWN_EN
      push_run(2, 2, bases, 2, 0);
`else
      push_run(2, 2, bases, 2, 1);
`endif
      load_pulse();
      run_traffic(-1, 0, -1);

      // three-cycle stall at beat 3
      bases = '0; bases[0 +: AW] = 9'd16;
      set_cfg(2'b10, 4'd1, bases, 9'd0, 1'b1);
      push_run(2, 1, bases, 0, 1);
      load_pulse();
      run_traffic(3, 3, -1);

      // restart on beat 3 with base 200
      push_run(2, 1, bases, 0, 1);
      load_pulse();
      run_traffic(-1, 0, 3);
      bases[0 +: AW] = 9'd200;
      set_cfg(2'b10, 4'd1, bases, 9'd0, 1'b1);
      bus.load = 1'b1;
      @(negedge clk);
      chk("restart_addr_before", 32'(bus.addr), 19);
      chk("restart_valid", 32'(bus.addr_valid), 1);
      q.delete();
      push_run(2, 1, bases, 0, 1);
      @(posedge clk);
      #1;
      bus.load = 1'b0;
      run_traffic(-1, 0, -1);

      // wrap past the top of the VRF
      bases = '0; bases[0 +: AW] = 9'd510;
      set_cfg(2'b10, 4'd1, bases, 9'd0, 1'b1);
      push_run(2, 1, bases, 0, 1);
      load_pulse();
      run_traffic(-1, 0, -1);

      // reset in the middle of a run
      push_run(2, 1, bases, 0, 1);
      load_pulse();
      run_traffic(-1, 0, 4);
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("midrst_valid", 32'(bus.addr_valid), 0);
      chk("midrst_busy", 32'(bus.busy), 0);
      chk("midrst_done", 32'(bus.done), 0);
      chk("midrst_addr", 32'(bus.addr), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      step();
      @(negedge clk);
      chk("midrst_no_done", 32'(bus.done), 0);
      @(posedge clk);
      #1;

      // reserved SEW must not start a run
      set_cfg(2'b11, 4'd1, bases, 9'd0, 1'b1);
      load_pulse();
      @(negedge clk);
      chk("sew11_busy", 32'(bus.busy), 0);
      chk("sew11_valid", 32'(bus.addr_valid), 0);
      @(posedge clk);
      #1;

      // seg_cnt 0 acts as one register; half-word with offset
      bases = '0; bases[0 +: AW] = 9'd16;
      set_cfg(2'b01, 4'd0, bases, 9'd3, 1'b1);
      push_run(1, 0, bases, 3, 1);
      load_pulse();
      run_traffic(-1, 0, -1);

      // seg_cnt 9 saturates at eight registers
      for (int k = 0; k < NS; k++) bases[k*AW +: AW] = AW'(k * 20 + 5);
      set_cfg(2'b10, 4'd9, bases, 9'd1, 1'b1);
      push_run(2, 9, bases, 1, 1);
      load_pulse();
      run_traffic(-1, 0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
